alu_cmd_issuer: RTL and testbench

Initiator side of the ALU start/ready handshake. Accepts operation commands on a valid/ready interface and drives start/opcode/A/B into the ALU. Waits for ALU ready, then captures the result and Z/C/V/S/E flags into a held response for a downstream consumer. Sits between the control sequencer and the ALU, replacing ad-hoc start pulsing; adds a completion timeout and error/operation counters.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_cmd_issuer_sat_counter.sv | 19 +
 rtl/alu_cmd_issuer.sv | 122 ++++++++++++
 tb/tb_alu_cmd_issuer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command issuer: opcodes, flag/status bit
// positions and the issuer state encoding.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_EQ  = 4'b1011;

  // Bit positions inside alu_flags / rsp_status; the timeout bit sits above the ALU flags.
  localparam int FLG_Z       = 0;
  localparam int FLG_C       = 1;
  localparam int FLG_V       = 2;
  localparam int FLG_S       = 3;
  localparam int FLG_E       = 4;
  localparam int STS_TIMEOUT = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } issuer_state_t;

endpackage

// File: rtl/alu_cmd_issuer_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Initiator side of the ALU start/ready handshake: issues one command at a
// time, waits for completion or timeout, and holds the response for a consumer.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int N              = 8,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TAG_W          = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_opcode,
  input  logic [N-1:0]     cmd_a,
  input  logic [N-1:0]     cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic             alu_start,
  output logic [3:0]       alu_opcode,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  input  logic             alu_ready,
  input  logic [2*N-1:0]   alu_result,
  input  logic [4:0]       alu_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [2*N-1:0]   rsp_result,
  output logic [5:0]       rsp_status,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [15:0]      ops_done,
  output logic [15:0]      err_count
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  issuer_state_t state, state_next;
  logic [CW-1:0] to_cnt;
  logic          to_expired;
  logic          handoff;
  logic          rsp_is_err;

  assign to_expired = (to_cnt == TO_LAST);
  assign handoff    = (state == ST_RESP) && rsp_ready;
  assign rsp_is_err = rsp_status[FLG_E] | rsp_status[STS_TIMEOUT];

  // Outputs decode straight from the state register so reset clears them asynchronously.
  assign cmd_ready = rst_n && (state == ST_IDLE);
  assign alu_start = (state == ST_ISSUE);
  assign rsp_valid = (state == ST_RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (cmd_valid) state_next = ST_ISSUE;
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT:  if (alu_ready || to_expired) state_next = ST_RESP;
      ST_RESP:  if (rsp_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // alu_ready is deliberately not looked at in ISSUE: it may still be high from the last op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_tag    <= '0;
      rsp_result <= '0;
      rsp_status <= '0;
      to_cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            alu_opcode <= cmd_opcode;
            alu_a      <= cmd_a;
            alu_b      <= cmd_b;
            rsp_tag    <= cmd_tag;
          end
        end
        ST_ISSUE: to_cnt <= '0;
        ST_WAIT: begin
          if (alu_ready) begin
            rsp_result <= alu_result;
            rsp_status <= {1'b0, alu_flags};
          end else if (to_expired) begin
            rsp_result <= '0;
            rsp_status <= 6'b100000;
          end else begin
            to_cnt <= to_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  sat_counter #(.W(16)) u_ops_done (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (handoff),
    .count (ops_done)
  );

  sat_counter #(.W(16)) u_err_count (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (handoff && rsp_is_err),
    .count (err_count)
  );

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer: a behavioural ALU stub, a response
// scoreboard fed by the stimulus, and a monitor that pops on each handoff.
module tb_alu_cmd_issuer;
  import alu_pkg::*;

  localparam int N     = 8;
  localparam int TO    = 64;
  localparam int TAG_W = 4;

  logic             clk, rst_n;
  logic             cmd_valid, cmd_ready;
  logic [3:0]       cmd_opcode;
  logic [N-1:0]     cmd_a, cmd_b;
  logic [TAG_W-1:0] cmd_tag;
  logic             alu_start;
  logic [3:0]       alu_opcode;
  logic [N-1:0]     alu_a, alu_b;
  logic             alu_ready;
  logic [2*N-1:0]   alu_result;
  logic [4:0]       alu_flags;
  logic             rsp_valid, rsp_ready;
  logic [2*N-1:0]   rsp_result;
  logic [5:0]       rsp_status;
  logic [TAG_W-1:0] rsp_tag;
  logic [15:0]      ops_done, err_count;

  typedef struct packed {
    logic [2*N-1:0]   result;
    logic [5:0]       status;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   exp_ops = 0;
  int   exp_err = 0;
  int   alu_delay = 3;
  bit   alu_never = 0;

  alu_cmd_issuer #(.N(N), .TIMEOUT_CYCLES(TO), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_tag    (cmd_tag),
    .alu_start  (alu_start),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ready  (alu_ready),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_status (rsp_status),
    .rsp_tag    (rsp_tag),
    .ops_done   (ops_done),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void aluCalc(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                                  output logic [2*N-1:0] r, output logic [4:0] f);
    logic signed [2*N-1:0] sa, sb;
    sa = 16'(signed'(a));
    sb = 16'(signed'(b));
    f  = '0;
    r  = '0;
    case (op)
      OP_ADD: r = sa + sb;
      OP_SUB: r = sa - sb;
      OP_MUL: r = sa * sb;
      OP_DIV: if (b == '0) f[FLG_E] = 1'b1; else r = sa / sb;
      OP_EQ:  r = (a == b) ? '0 : 16'd1;
      default: f[FLG_E] = 1'b1;
    endcase
    if (!f[FLG_E]) begin
      f[FLG_Z] = (r == '0);
      f[FLG_S] = r[2*N-1];
    end
  endfunction

  // Behavioural ALU: ready stays high after completion until the next start is seen.
  initial begin
    logic [2*N-1:0] m_res;
    logic [4:0]     m_flg;
    int             m_cnt;
    bit             m_busy, m_start;
    m_busy = 0; m_start = 0; m_cnt = 0; m_res = '0; m_flg = '0;
    alu_ready = 1'b0; alu_result = '0; alu_flags = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_busy = 0; m_start = 0;
      end else if (alu_start) begin
        m_start = 1;
        aluCalc(alu_opcode, alu_a, alu_b, m_res, m_flg);
        m_cnt = alu_delay;
      end
      @(posedge clk);
      #1;
      if (!rst_n) begin
        alu_ready = 1'b0; m_busy = 0; m_start = 0;
      end else begin
        if (m_start) begin
          alu_ready = 1'b0; m_start = 0; m_busy = !alu_never;
        end
        if (m_busy) begin
          if (m_cnt == 0) begin
            alu_ready = 1'b1; alu_result = m_res; alu_flags = m_flg; m_busy = 0;
          end else begin
            m_cnt--;
          end
        end
      end
    end
  end

  // Scoreboard monitor: a handoff is visible at the negedge before the posedge that takes it.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL unexpected_rsp: actual tag=%0h required none", rsp_tag);
        end else begin
          e = exp_q.pop_front();
          checkOutput("rsp_result", 32'(rsp_result), 32'(e.result));
          checkOutput("rsp_status", 32'(rsp_status), 32'(e.status));
          checkOutput("rsp_tag",    32'(rsp_tag),    32'(e.tag));
        end
      end
    end
  end

  task automatic sendCmd(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [TAG_W-1:0] tag, output bit ok);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL cmd_ready_wait: actual=0 required=1");
      return;
    end
    cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_tag = tag;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                               input logic [TAG_W-1:0] tag, input logic [2*N-1:0] exp_res,
                               input logic [5:0] exp_sts, input int delay, input bit never,
                               input int exp_waits, input int hold);
    bit ok, got;
    int starts, waits;
    alu_delay = delay;
    alu_never = never;
    rsp_ready = (hold == 0);
    sendCmd(op, a, b, tag, ok);
    if (!ok) return;
    exp_q.push_back('{result: exp_res, status: exp_sts, tag: tag});
    @(negedge clk);
    checkOutput("start_latency", 32'(alu_start), 32'd1);
    checkOutput("cmd_ready_busy", 32'(cmd_ready), 32'd0);
    starts = 1; waits = 0; got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1;
        break;
      end
      if (alu_start) starts++;
      else waits++;
    end
    if (!got) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL rsp_wait: actual rsp_valid=0 required=1");
      void'(exp_q.pop_back());
      return;
    end
    checkOutput("start_pulses", 32'(starts), 32'd1);
    checkOutput("wait_cycles", 32'(waits), 32'(exp_waits));
    if (hold > 0) begin
      for (int k = 0; k < hold; k++) begin
        if (k > 0) @(negedge clk);
        checkOutput("hold_valid",  32'(rsp_valid),  32'd1);
        checkOutput("hold_result", 32'(rsp_result), 32'(exp_res));
        checkOutput("hold_status", 32'(rsp_status), 32'(exp_sts));
        checkOutput("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        checkOutput("hold_opcode", 32'(alu_opcode), 32'(op));
      end
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      @(negedge clk);
    end
    @(negedge clk);
    exp_ops++;
    if (exp_sts[FLG_E] || exp_sts[STS_TIMEOUT]) exp_err++;
    checkOutput("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    checkOutput("ops_done",  32'(ops_done),  32'(exp_ops));
    checkOutput("err_count", 32'(err_count), 32'(exp_err));
    checkOutput("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    checkOutput("opcode_held", 32'(alu_opcode), 32'(op));
  endtask

  task automatic checkResetState(input string tagname);
    checkOutput({tagname, "_alu_start"}, 32'(alu_start), 32'd0);
    checkOutput({tagname, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    checkOutput({tagname, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
    checkOutput({tagname, "_ops_done"},  32'(ops_done),  32'd0);
    checkOutput({tagname, "_err_count"}, 32'(err_count), 32'd0);
    checkOutput({tagname, "_alu_opcode"}, 32'(alu_opcode), 32'd0);
    checkOutput({tagname, "_rsp_result"}, 32'(rsp_result), 32'd0);
  endtask

  initial begin
    bit ok;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_opcode = '0; cmd_a = '0; cmd_b = '0;
    cmd_tag = '0; rsp_ready = 1'b1;
    #12;
    checkResetState("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);

    $display("[TB] directed vectors");
    applyStimulus(OP_ADD, 8'd10,  8'd5,   4'h1, 16'h000F, 6'b000000, 3,  0, 4,  0);
    applyStimulus(OP_SUB, 8'd10,  8'd20,  4'h2, 16'hFFF6, 6'b001000, 3,  0, 4,  0);
    applyStimulus(OP_DIV, 8'd50,  8'd0,   4'hA, 16'h0000, 6'b010000, 3,  0, 4,  0);
    applyStimulus(OP_ADD, 8'd1,   8'd1,   4'h3, 16'h0000, 6'b100000, 3,  1, 64, 0);
    applyStimulus(OP_MUL, 8'd3,   8'hFC,  4'h4, 16'hFFF4, 6'b001000, 3,  0, 4,  5);
    applyStimulus(OP_SUB, 8'd5,   8'd5,   4'h5, 16'h0000, 6'b000001, 62, 0, 63, 0);
    applyStimulus(OP_ADD, 8'd127, 8'd1,   4'h6, 16'h0080, 6'b000000, 63, 0, 64, 0);

    $display("[TB] reset during WAIT");
    alu_delay = 20; alu_never = 0; rsp_ready = 1'b1;
    sendCmd(OP_MUL, 8'd10, 8'hFB, 4'h7, ok);
    repeat (4) @(negedge clk);
    checkOutput("pre_reset_ops", 32'(ops_done), 32'(exp_ops));
    rst_n = 1'b0;
    #1;
    checkResetState("wait_reset");
    exp_ops = 0; exp_err = 0;
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] reset during ISSUE");
    sendCmd(OP_ADD, 8'd2, 8'd2, 4'h8, ok);
    @(negedge clk);
    checkOutput("issue_start", 32'(alu_start), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("issue_reset_start", 32'(alu_start), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("no_rsp_after_reset", 32'(rsp_valid), 32'd0);

    applyStimulus(OP_EQ, 8'd25, 8'd25, 4'hF, 16'h0000, 6'b000001, 3, 0, 4, 0);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
